psum_accum: RTL and testbench

Read-modify-write accumulator between the PE array psum outputs and the per-row psum memories. Each valid psum is added to the value already stored at its address, or overwrites it on the first weight pass, so multi-pass convolutions reduce in place without host involvement. One independent 3-stage pipeline runs per array row, with address-hazard forwarding for back-to-back hits.

---
 rtl/psum_accum_if.sv | 34 +++
 rtl/psum_accum.sv | 138 +++++++++++++
 tb/tb_psum_accum.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_accum_if.sv
// Bundle of PE-array psum inputs, per-row memory ports and status for psum_accum.
// Latency: n/a (wires only); read port is combinational, write port is registered in the accumulator.
// Backpressure: none; every lane accepts one psum per cycle.
interface psum_accum_if #(
  parameter int ROWS   = 3,
  parameter int PSUM_W = 48,
  parameter int ADDR_W = 32,
  parameter int MEM_W  = 64
);
  logic                                first_pass;
  logic                                clr_ovf;
  logic [0:ROWS-1]                     psum_valid;
  logic [0:ROWS-1][ADDR_W-1:0]         psum_addr;
  logic [0:ROWS-1][PSUM_W-1:0]         psums;
  logic [0:ROWS-1][ADDR_W-1:0]         mem_rd_addr;
  logic [0:ROWS-1][MEM_W-1:0]          mem_rdata;
  logic [0:ROWS-1][ADDR_W-1:0]         mem_wr_addr;
  logic [0:ROWS-1][MEM_W/8-1:0]        mem_we;
  logic [0:ROWS-1][MEM_W-1:0]          mem_wdata;
  logic [0:ROWS-1]                     overflow;
  logic                                busy;

  // Environment side: PE array plus psum memories.
  modport master (
    output first_pass, clr_ovf, psum_valid, psum_addr, psums, mem_rdata,
    input  mem_rd_addr, mem_wr_addr, mem_we, mem_wdata, overflow, busy
  );

  // Accumulator side.
  modport slave (
    input  first_pass, clr_ovf, psum_valid, psum_addr, psums, mem_rdata,
    output mem_rd_addr, mem_wr_addr, mem_we, mem_wdata, overflow, busy
  );
endinterface

// File: rtl/psum_accum.sv
// Per-row read-modify-write psum accumulator (overwrite on first pass, add otherwise) with S2/W forwarding.
// Latency: psum at cycle T -> write port active in T+2; optional saturation via macro PSUM_ACCUM_SAT_EN.
// Backpressure: none; each lane sustains one psum per cycle, lanes fully independent.
module psum_accum #(
  parameter int ROWS   = 3,
  parameter int PSUM_W = 48,
  parameter int ADDR_W = 32,
  parameter int MEM_W  = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  psum_accum_if.slave  bus
);

  localparam int NB = MEM_W / 8;

  // Byte enables covering the psum bits; the upper bytes carry the zero extension.
  function automatic logic [NB-1:0] we_mask_f();
    logic [NB-1:0] m;
    m = '0;
    for (int b = 0; b < NB; b++) m[b] = (b < PSUM_W / 8);
    return m;
  endfunction

  localparam logic [NB-1:0] WE_MASK = we_mask_f();

`ifdef PSUM_ACCUM_SAT_EN
  localparam logic [PSUM_W-1:0] POS_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
  localparam logic [PSUM_W-1:0] NEG_MIN = {1'b1, {(PSUM_W-1){1'b0}}};
`endif

  // Stage registers, one slot per lane.
  logic [ROWS-1:0]   s1_vld_q, s1_first_q, s2_vld_q, w_vld_q, ovf_q;
  logic [ADDR_W-1:0] s1_addr_q [ROWS];
  logic [PSUM_W-1:0] s1_psum_q [ROWS];
  logic [ADDR_W-1:0] s2_addr_q [ROWS];
  logic [PSUM_W-1:0] s2_data_q [ROWS];
  logic [ADDR_W-1:0] w_addr_q  [ROWS];
  logic [PSUM_W-1:0] w_data_q  [ROWS];

  // S1 combinational results.
  logic [PSUM_W-1:0] opnd    [ROWS];
  logic [PSUM_W-1:0] sum_raw [ROWS];
  logic [PSUM_W-1:0] res_d   [ROWS];
  logic [ROWS-1:0]   ovf_raw;
  logic [ROWS-1:0]   ovf_set_d;

  // S1: pick the freshest copy of the addressed word, add, detect signed overflow.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      opnd[i]    = bus.mem_rdata[i][PSUM_W-1:0];
      sum_raw[i] = '0;
      res_d[i]   = '0;
      ovf_raw[i] = 1'b0;
      if (s1_first_q[i]) begin
        opnd[i] = '0;
      end else if (s2_vld_q[i] && (s2_addr_q[i] == s1_addr_q[i])) begin
        opnd[i] = s2_data_q[i];
      end else if (w_vld_q[i] && (w_addr_q[i] == s1_addr_q[i])) begin
        opnd[i] = w_data_q[i];
      end
      sum_raw[i] = opnd[i] + s1_psum_q[i];
      ovf_raw[i] = (opnd[i][PSUM_W-1] == s1_psum_q[i][PSUM_W-1]) &&
                   (sum_raw[i][PSUM_W-1] != opnd[i][PSUM_W-1]);
`ifdef PSUM_ACCUM_SAT_EN
      // Saturate toward the sign both operands share.
      if (ovf_raw[i]) res_d[i] = opnd[i][PSUM_W-1] ? NEG_MIN : POS_MAX;
      else            res_d[i] = sum_raw[i];
`else
      res_d[i] = sum_raw[i];
`endif
      ovf_set_d[i] = s1_vld_q[i] && ovf_raw[i];
    end
  end

  // Pipeline advance: S0 capture into S1, S1 result into S2, S2 write into the W history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= '0;
      s1_first_q <= '0;
      s2_vld_q   <= '0;
      w_vld_q    <= '0;
      for (int i = 0; i < ROWS; i++) begin
        s1_addr_q[i] <= '0;
        s1_psum_q[i] <= '0;
        s2_addr_q[i] <= '0;
        s2_data_q[i] <= '0;
        w_addr_q[i]  <= '0;
        w_data_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < ROWS; i++) begin
        s1_vld_q[i] <= bus.psum_valid[i];
        if (bus.psum_valid[i]) begin
          s1_addr_q[i]  <= bus.psum_addr[i];
          s1_psum_q[i]  <= bus.psums[i];
          s1_first_q[i] <= bus.first_pass;
        end
        s2_vld_q[i] <= s1_vld_q[i];
        if (s1_vld_q[i]) begin
          s2_addr_q[i] <= s1_addr_q[i];
          s2_data_q[i] <= res_d[i];
        end
        // W only tracks the write of the previous cycle, so distance >= 3 reads memory.
        w_vld_q[i] <= s2_vld_q[i];
        if (s2_vld_q[i]) begin
          w_addr_q[i] <= s2_addr_q[i];
          w_data_q[i] <= s2_data_q[i];
        end
      end
    end
  end

  // Sticky overflow flags; a new overflow beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < ROWS; i++) begin
        if (ovf_set_d[i])     ovf_q[i] <= 1'b1;
        else if (bus.clr_ovf) ovf_q[i] <= 1'b0;
      end
    end
  end

  // Output ports: read address passes straight through, write port comes from S2.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      bus.mem_rd_addr[i] = bus.psum_addr[i];
      bus.mem_wr_addr[i] = s2_addr_q[i];
      bus.mem_wdata[i]   = MEM_W'(s2_data_q[i]);
      bus.mem_we[i]      = s2_vld_q[i] ? WE_MASK : '0;
      bus.overflow[i]    = ovf_q[i];
    end
    bus.busy = (|bus.psum_valid) || (|s1_vld_q) || (|s2_vld_q);
  end

endmodule

// File: tb/tb_psum_accum.sv
// Self-checking bench for psum_accum: vector table, hazard/overflow/reset sequences, random scoreboard.
// Latency: expects writes at T+2 after each psum; memories modelled with 1-cycle read-first latency.
// Backpressure: none; stimulus drives one psum per lane per cycle at will.
module tb_psum_accum;
  localparam int ROWS   = 3;
  localparam int PSUM_W = 48;
  localparam int ADDR_W = 32;
  localparam int MEM_W  = 64;
  localparam int NB     = MEM_W / 8;
  localparam int DEPTH  = 256;
  localparam longint MAXV = (64'sd1 <<< (PSUM_W-1)) - 64'sd1;
  localparam longint MINV = -(64'sd1 <<< (PSUM_W-1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  psum_accum_if #(.ROWS(ROWS), .PSUM_W(PSUM_W), .ADDR_W(ADDR_W), .MEM_W(MEM_W)) bus ();

  psum_accum #(.ROWS(ROWS), .PSUM_W(PSUM_W), .ADDR_W(ADDR_W), .MEM_W(MEM_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory model (read-first, 1-cycle read latency) ----------------
  logic [MEM_W-1:0] mem [ROWS][DEPTH];
  logic             mem_init = 1'b0;
  logic             pl_vld = 1'b0;
  int               pl_lane = 0;
  logic [7:0]       pl_addr = '0;
  logic [MEM_W-1:0] pl_data = '0;

  always @(posedge clk) begin
    for (int l = 0; l < ROWS; l++) begin
      bus.mem_rdata[l] <= mem[l][bus.mem_rd_addr[l][7:0]];
      for (int b = 0; b < NB; b++)
        if (bus.mem_we[l][b])
          mem[l][bus.mem_wr_addr[l][7:0]][8*b +: 8] <= bus.mem_wdata[l][8*b +: 8];
    end
    if (mem_init) begin
      for (int l = 0; l < ROWS; l++)
        for (int a = 0; a < DEPTH; a++) mem[l][a] <= '0;
    end
    if (pl_vld) mem[pl_lane][pl_addr] <= pl_data;
  end

  // ---------------- reference model: serial accumulation per lane ----------------
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [MEM_W-1:0]  data;
  } wr_t;

  logic [PSUM_W-1:0] ref_mem [ROWS][DEPTH];
  wr_t               exp_q   [ROWS][$];
  logic [ROWS-1:0]   ovf_exp;
  wr_t               mon_e;

  task automatic model_op(input int l, input bit first, input int addr, input logic [PSUM_W-1:0] p);
    logic signed [PSUM_W-1:0] as_v, bs_v;
    logic [PSUM_W-1:0] r;
    longint a, b, s;
`ifdef PSUM_ACCUM_SAT_EN
    longint lim;
`endif
    as_v = first ? '0 : ref_mem[l][addr];
    bs_v = p;
    a = as_v;
    b = bs_v;
    s = a + b;
    r = s[PSUM_W-1:0];
    if (s > MAXV || s < MINV) begin
      ovf_exp[l] = 1'b1;
`ifdef PSUM_ACCUM_SAT_EN
      lim = (s > MAXV) ? MAXV : MINV;
      r = lim[PSUM_W-1:0];
`endif
    end
    ref_mem[l][addr] = r;
    exp_q[l].push_back('{addr: ADDR_W'(addr), data: MEM_W'(r)});
  endtask

  // Every write the DUT issues must be the next one the model expects for that lane.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int l = 0; l < ROWS; l++) begin
        if (bus.mem_we[l] != '0) begin
          if (exp_q[l].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write lane %0d: got addr %h data %h, required no write",
                     l, bus.mem_wr_addr[l], bus.mem_wdata[l]);
          end else begin
            mon_e = exp_q[l].pop_front();
            check("wr_we", 64'(bus.mem_we[l]), 64'h3F);
            check("wr_addr", 64'(bus.mem_wr_addr[l]), 64'(mon_e.addr));
            check("wr_data", bus.mem_wdata[l], mon_e.data);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.psum_valid = '0;
  endtask

  task automatic set_in(input int l, input int addr, input logic [PSUM_W-1:0] p, input bit model);
    bus.psum_valid[l] = 1'b1;
    bus.psum_addr[l]  = ADDR_W'(addr);
    bus.psums[l]      = p;
    if (model) model_op(l, bus.first_pass, addr, p);
  endtask

  task automatic preload(input int l, input int addr, input logic [PSUM_W-1:0] v);
    pl_lane = l;
    pl_addr = 8'(addr);
    pl_data = MEM_W'(v);
    pl_vld  = 1'b1;
    ref_mem[l][addr] = v;
    step();
    pl_vld = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr_ovf = 1'b1;
    step();
    bus.clr_ovf = 1'b0;
  endtask

  typedef struct {
    bit                first;
    int                addr;
    logic [PSUM_W-1:0] psum;
    logic [MEM_W-1:0]  exp;
  } vec_t;

  vec_t tv [7];

  initial begin
    tv[0] = '{1'b1, 4, 48'd5,               64'd5};
    tv[1] = '{1'b0, 4, 48'd7,               64'd12};
    tv[2] = '{1'b0, 4, 48'hFFFF_FFFF_FFEC,  64'h0000_FFFF_FFFF_FFF8};
    tv[3] = '{1'b1, 4, 48'hFFFF_FFFF_FFFD,  64'h0000_FFFF_FFFF_FFFD};
    tv[4] = '{1'b0, 4, 48'd3,               64'd0};
    tv[5] = '{1'b1, 8, 48'h7FFF_FFFF_FFFF,  64'h0000_7FFF_FFFF_FFFF};
    tv[6] = '{1'b0, 8, 48'h8000_0000_0001,  64'd0};

    bus.first_pass = 1'b0;
    bus.clr_ovf    = 1'b0;
    bus.psum_valid = '0;
    bus.psum_addr  = '0;
    bus.psums      = '0;
    ovf_exp        = '0;
    for (int l = 0; l < ROWS; l++)
      for (int a = 0; a < DEPTH; a++) ref_mem[l][a] = '0;

    // ---- reset state ----
    mem_init = 1'b1;
    step();
    mem_init = 1'b0;
    step();
    for (int l = 0; l < ROWS; l++) begin
      check("rst_we", 64'(bus.mem_we[l]), 64'd0);
      check("rst_wr_addr", 64'(bus.mem_wr_addr[l]), 64'd0);
      check("rst_wdata", bus.mem_wdata[l], 64'd0);
    end
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    bus.psum_valid[1] = 1'b1;
    bus.psum_addr[1]  = 32'h0000_00A5;
    #1;
    check("rst_busy_in", 64'(bus.busy), 64'd1);
    check("rst_rd_addr", 64'(bus.mem_rd_addr[1]), 64'h A5);
    idle();
    step();
    rst_n = 1'b1;
    step();

    // ---- vector table on lane 0, issues spaced 4 cycles apart ----
    for (int i = 0; i < 7; i++) begin
      bus.first_pass = tv[i].first;
      set_in(0, tv[i].addr, tv[i].psum, 1'b1);
      step();
      idle();
      step();
      check("tv_we", 64'(bus.mem_we[0]), 64'h3F);
      check("tv_wr_addr", 64'(bus.mem_wr_addr[0]), 64'(tv[i].addr));
      check("tv_wdata", bus.mem_wdata[0], tv[i].exp);
      check("tv_we_lane1", 64'(bus.mem_we[1]), 64'd0);
      step();
      step();
    end

    // ---- hazard: +1 four times at addr 9 with 0/1/2 idle cycles between ----
    bus.first_pass = 1'b0;
    for (int g = 0; g < 3; g++) begin
      preload(0, 9, 48'd100);
      for (int k = 0; k < 4; k++) begin
        set_in(0, 9, 48'd1, 1'b1);
        step();
        idle();
        for (int d = 0; d < g; d++) step();
      end
      for (int d = 0; d < 5; d++) step();
      check("hazard_final", mem[0][9], 64'd104);
    end

    // ---- all lanes every cycle for 16 cycles, random psums ----
    for (int c = 0; c < 16; c++) begin
      bus.first_pass = ($urandom_range(0, 3) == 0);
      for (int l = 0; l < ROWS; l++)
        set_in(l, $urandom_range(0, 7), PSUM_W'({$urandom, $urandom}), 1'b1);
      step();
    end
    idle();
    check("busy_t1", 64'(bus.busy), 64'd1);
    step();
    check("busy_t2", 64'(bus.busy), 64'd1);
    step();
    check("busy_t3", 64'(bus.busy), 64'd0);
    for (int d = 0; d < 3; d++) step();
    for (int l = 0; l < ROWS; l++) begin
      check("lanes_q_empty", 64'(exp_q[l].size()), 64'd0);
      for (int a = 0; a < 8; a++) check("lanes_mem", mem[l][a], MEM_W'(ref_mem[l][a]));
    end
    check("lanes_overflow", 64'(bus.overflow), 64'(ovf_exp));

    // ---- longer random run with sparse valids and mixed first_pass ----
    for (int c = 0; c < 400; c++) begin
      bus.first_pass = ($urandom_range(0, 7) == 0);
      for (int l = 0; l < ROWS; l++) begin
        if ($urandom_range(0, 2) != 0)
          set_in(l, $urandom_range(0, 5), PSUM_W'({$urandom, $urandom}) >>> $urandom_range(0, 40), 1'b1);
        else
          bus.psum_valid[l] = 1'b0;
      end
      step();
    end
    idle();
    for (int d = 0; d < 5; d++) step();
    for (int l = 0; l < ROWS; l++) begin
      check("rand_q_empty", 64'(exp_q[l].size()), 64'd0);
      for (int a = 0; a < 6; a++) check("rand_mem", mem[l][a], MEM_W'(ref_mem[l][a]));
    end
    check("rand_overflow", 64'(bus.overflow), 64'(ovf_exp));

    // ---- overflow: positive and negative limits ----
    pulse_clr();
    ovf_exp = '0;
    check("ovf_cleared", 64'(bus.overflow), 64'd0);
    bus.first_pass = 1'b0;
    preload(0, 20, 48'h7FFF_FFFF_FFFF);
    set_in(0, 20, 48'd1, 1'b1);
    step();
    idle();
    step();
`ifdef PSUM_ACCUM_SAT_EN
    check("ovf_pos_wdata", bus.mem_wdata[0], 64'h0000_7FFF_FFFF_FFFF);
`else
    check("ovf_pos_wdata", bus.mem_wdata[0], 64'h0000_8000_0000_0000);
`endif
    check("ovf_pos_flag", 64'(bus.overflow), 64'b100);
    step();
    pulse_clr();
    check("ovf_clr", 64'(bus.overflow), 64'd0);
    preload(2, 21, 48'h8000_0000_0000);
    set_in(2, 21, 48'hFFFF_FFFF_FFFF, 1'b1);
    step();
    idle();
    step();
`ifdef PSUM_ACCUM_SAT_EN
    check("ovf_neg_wdata", bus.mem_wdata[2], 64'h0000_8000_0000_0000);
`else
    check("ovf_neg_wdata", bus.mem_wdata[2], 64'h0000_7FFF_FFFF_FFFF);
`endif
    check("ovf_neg_flag", 64'(bus.overflow), 64'b001);
    step();
    pulse_clr();
    // Clear lands in the same cycle as a new overflow: the flag must stay set.
    preload(0, 20, 48'h7FFF_FFFF_FFFF);
    set_in(0, 20, 48'd1, 1'b1);
    step();
    idle();
    bus.clr_ovf = 1'b1;
    step();
    bus.clr_ovf = 1'b0;
    check("ovf_set_wins", 64'(bus.overflow), 64'b100);
    for (int d = 0; d < 3; d++) step();

    // ---- reset one cycle after a psum: it must never be written ----
    bus.first_pass = 1'b1;
    set_in(1, 30, 48'd77, 1'b0);
    step();
    idle();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check("midrst_we", 64'(bus.mem_we), 64'd0);
      step();
    end
    rst_n = 1'b1;
    #1;
    check("midrst_overflow", 64'(bus.overflow), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    for (int d = 0; d < 4; d++) begin
      check("postrst_we", 64'(bus.mem_we), 64'd0);
      step();
    end
    check("postrst_mem", mem[1][30], MEM_W'(ref_mem[1][30]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
